// File: rtl/tmr_vote_pkg.sv
// Shared types and constants for the triple-redundant vote sequencer.
package tmr_vote_pkg;

    localparam int unsigned NCH     = 3;
    localparam int unsigned ErrCntW = 2;

    typedef logic [ErrCntW-1:0] err_cnt_t;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        VOTE,
        HOLD
    } state_t;

    // Number of set bits in a 3-bit channel vector.
    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/maj3_vec.sv
// Bitwise 2-of-3 majority of three equal-width words.
module maj3_vec #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] maj_o
);

    assign maj_o = (a_i & b_i) | (b_i & c_i) | (c_i & a_i);

endmodule

// File: rtl/tmr_vote_sequencer.sv
// Collects one word per redundant channel, votes, and hands the result downstream.
// Channels that keep disagreeing are masked out of later votes until clr_fault.
module tmr_vote_sequencer
    import tmr_vote_pkg::*;
#(
    parameter int unsigned W          = 8,
    parameter int unsigned TIMEOUT    = 15,
    parameter int unsigned FAIL_LIMIT = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [2:0]   in_valid,
    output logic [2:0]   in_ready,
    input  logic [W-1:0] in_data0,
    input  logic [W-1:0] in_data1,
    input  logic [W-1:0] in_data2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_degraded,
    output logic         vote_fail,
    output logic [2:0]   err_chan,
    output logic [2:0]   fault_mask,
    input  logic         clr_fault
);

    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
    typedef logic [TmoW-1:0] tmo_t;
    // Counter holds TIMEOUT in the VOTE cycle after a timeout.
    localparam tmo_t     TmoLast = tmo_t'(TIMEOUT - 1);
    localparam err_cnt_t FailLim = err_cnt_t'(FAIL_LIMIT);

    state_t         state_q;
    logic [NCH-1:0] cap_q;
    logic [NCH-1:0] mask_q;
    logic [NCH-1:0] mask_d;
    logic [NCH-1:0] err_chan_q;
    logic [W-1:0]   data_q [NCH];
    logic [W-1:0]   in_word [NCH];
    tmo_t           tmo_q;
    err_cnt_t       cnt_q [NCH];
    err_cnt_t       cnt_d [NCH];
    logic           out_valid_q;
    logic [W-1:0]   out_data_q;
    logic           out_degraded_q;
    logic           vote_fail_q;

    logic           collecting;
    logic [NCH-1:0] take;
    logic           all_in;
    logic [NCH-1:0] present;
    logic [W-1:0]   maj_w;
    logic [W-1:0]   pair_a;
    logic [W-1:0]   pair_b;
    logic [W-1:0]   v_data;
    logic           v_emit;
    logic           v_deg;
    logic           v_fail;
    logic [NCH-1:0] v_err;

    assign in_word[0] = in_data0;
    assign in_word[1] = in_data1;
    assign in_word[2] = in_data2;

    // Masked channels always drain; unmasked ones accept only while not yet captured.
    assign collecting = (state_q == IDLE) || (state_q == COLLECT);
    assign in_ready   = mask_q | ({NCH{collecting}} & ~cap_q);
    assign take       = in_valid & in_ready & ~mask_q;
    assign all_in     = &(cap_q | take | mask_q);
    assign present    = cap_q & ~mask_q;

    maj3_vec #(.W(W)) u_maj (
        .a_i   (data_q[0]),
        .b_i   (data_q[1]),
        .c_i   (data_q[2]),
        .maj_o (maj_w)
    );

    // With exactly two present, pair_a/pair_b are those two words in channel order.
    assign pair_a = present[0] ? data_q[0] : data_q[1];
    assign pair_b = present[2] ? data_q[2] : data_q[1];

    // Vote outcome for the words captured so far; consumed only in VOTE.
    always_comb begin
        v_data = '0;
        v_emit = 1'b0;
        v_deg  = 1'b0;
        v_fail = 1'b0;
        v_err  = ~cap_q & ~mask_q;
        unique case (popcount3(present))
            2'd3: begin
                v_data = maj_w;
                v_emit = 1'b1;
                for (int i = 0; i < NCH; i++) begin
                    if (data_q[i] != maj_w) v_err[i] = 1'b1;
                end
                v_deg = |v_err;
            end
            2'd2: begin
                if (pair_a == pair_b) begin
                    v_data = pair_a;
                    v_emit = 1'b1;
                    v_deg  = 1'b1;
                end else begin
                    v_fail = 1'b1;
                    v_err  = v_err | present;
                end
            end
            2'd1: begin
                v_data = present[0] ? data_q[0] : (present[1] ? data_q[1] : data_q[2]);
                v_emit = 1'b1;
                v_deg  = 1'b1;
            end
            default: ;
        endcase
    end

    // Error counters and mask; clr_fault overrides anything the vote would do.
    always_comb begin
        mask_d = mask_q;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (state_q == VOTE) begin
                if (v_err[i]) begin
                    if (cnt_q[i] != FailLim) cnt_d[i] = cnt_q[i] + err_cnt_t'(1);
                end else if (present[i]) begin
                    cnt_d[i] = '0;
                end
            end
            if (cnt_d[i] == FailLim) mask_d[i] = 1'b1;
            if (clr_fault) begin
                cnt_d[i]  = '0;
                mask_d[i] = 1'b0;
            end
        end
    end

    // Sequencer FSM with capture registers, timeout counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cap_q          <= '0;
            mask_q         <= '0;
            tmo_q          <= '0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_degraded_q <= 1'b0;
            vote_fail_q    <= 1'b0;
            err_chan_q     <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            mask_q      <= mask_d;
            vote_fail_q <= 1'b0;
            err_chan_q  <= '0;
            cap_q       <= cap_q | take;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
                if (take[i]) data_q[i] <= in_word[i];
            end
            unique case (state_q)
                IDLE: begin
                    if (|take) begin
                        tmo_q   <= '0;
                        state_q <= all_in ? VOTE : COLLECT;
                    end
                end
                COLLECT: begin
                    tmo_q <= tmo_q + tmo_t'(1);
                    if (all_in || (tmo_q == TmoLast)) state_q <= VOTE;
                end
                VOTE: begin
                    cap_q       <= '0;
                    err_chan_q  <= v_err;
                    vote_fail_q <= v_fail;
                    if (v_emit) begin
                        out_valid_q    <= 1'b1;
                        out_data_q     <= v_data;
                        out_degraded_q <= v_deg;
                        state_q        <= HOLD;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_degraded = out_degraded_q;
    assign vote_fail    = vote_fail_q;
    assign err_chan     = err_chan_q;
    assign fault_mask   = mask_q;

endmodule

// File: tb/tb_tmr_vote_sequencer.sv
// Randomized and directed bench for tmr_vote_sequencer against a transaction-level model.
module tb_tmr_vote_sequencer;

    localparam int W   = 8;
    localparam int TMO = 15;
    localparam int LIM = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   in_valid;
    logic [2:0]   in_ready;
    logic [W-1:0] in_data0, in_data1, in_data2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_degraded;
    logic         vote_fail;
    logic [2:0]   err_chan;
    logic [2:0]   fault_mask;
    logic         clr_fault;

    int checks = 0;
    int errors = 0;

    // Model state: per-channel consecutive-error count and mask.
    int         cnt_m [3];
    logic [2:0] mask_m;

    tmr_vote_sequencer #(.W(W), .TIMEOUT(TMO), .FAIL_LIMIT(LIM)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data0     (in_data0),
        .in_data1     (in_data1),
        .in_data2     (in_data2),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_degraded (out_degraded),
        .vote_fail    (vote_fail),
        .err_chan     (err_chan),
        .fault_mask   (fault_mask),
        .clr_fault    (clr_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_ch(input int i, input logic v, input logic [W-1:0] d);
        in_valid[i] = v;
        case (i)
            0: in_data0 = d;
            1: in_data1 = d;
            default: in_data2 = d;
        endcase
    endtask

    // Masked channels stream garbage continuously; others idle with garbage data.
    task automatic drive_background();
        for (int i = 0; i < 3; i++) set_ch(i, mask_m[i], W'($urandom));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) cnt_m[i] = 0;
        mask_m = 3'b000;
    endtask

    // Expected vote outcome computed from the channel words by counting.
    task automatic model_vote(input logic [2:0] pres, input logic [W-1:0] w0, w1, w2,
                              output logic emit, output logic fail, output logic [W-1:0] res,
                              output logic deg, output logic [2:0] err);
        logic [W-1:0] w [3];
        logic [W-1:0] pw [$];
        int n, ones;
        w[0] = w0; w[1] = w1; w[2] = w2;
        n = 0;
        for (int i = 0; i < 3; i++) if (pres[i]) begin n++; pw.push_back(w[i]); end
        emit = 0; fail = 0; res = '0; deg = 0;
        err = ~pres & ~mask_m;
        if (n == 3) begin
            for (int b = 0; b < W; b++) begin
                ones = int'(w0[b]) + int'(w1[b]) + int'(w2[b]);
                res[b] = (ones >= 2);
            end
            emit = 1;
            for (int i = 0; i < 3; i++) if (w[i] != res) err[i] = 1'b1;
        end else if (n == 2) begin
            if (pw[0] == pw[1]) begin res = pw[0]; emit = 1; end
            else begin fail = 1; err = err | pres; end
        end else if (n == 1) begin
            res = pw[0];
            emit = 1;
        end
        deg = emit && ((n < 3) || ((err & pres) != 0));
    endtask

    task automatic model_update(input logic [2:0] pres, input logic [2:0] err, input logic clr);
        for (int i = 0; i < 3; i++) begin
            if (!mask_m[i]) begin
                if (err[i]) cnt_m[i] = (cnt_m[i] + 1 > LIM) ? LIM : cnt_m[i] + 1;
                else if (pres[i]) cnt_m[i] = 0;
                if (cnt_m[i] >= LIM) mask_m[i] = 1'b1;
            end
        end
        if (clr) model_reset();
    endtask

    // One transaction: channel i in 'send' offers its word at cycle offset off[i].
    task automatic run_txn(input logic [2:0] send, input logic [W-1:0] w0, w1, w2,
                           input int o0, o1, o2, input int hold, input int clr_at);
        logic [W-1:0] w [3];
        int off [3];
        logic [2:0] pres;
        int f, l, e, t, t_seen;
        logic emit, fail, deg;
        logic [W-1:0] res;
        logic [2:0] err;
        w[0] = w0; w[1] = w1; w[2] = w2;
        off[0] = o0; off[1] = o1; off[2] = o2;
        pres = send & ~mask_m;
        f = 1000; l = -1;
        for (int i = 0; i < 3; i++) if (pres[i]) begin
            if (off[i] < f) f = off[i];
            if (off[i] > l) l = off[i];
        end
        e = (pres == ~mask_m) ? l + 2 : f + TMO + 2;
        model_vote(pres, w0, w1, w2, emit, fail, res, deg, err);
        t_seen = -1;
        t = 0;
        while (t <= e + 4 && t_seen < 0) begin
            @(negedge clk);
            if (t == 0) check_eq("idle_ready", 32'(in_ready), 32'(3'b111));
            if (out_valid || vote_fail) begin
                t_seen = t;
                drive_background();
                clr_fault = 1'b0;
                out_ready = (hold == 0);
            end else begin
                drive_background();
                for (int i = 0; i < 3; i++)
                    if (pres[i] && t == off[i]) set_ch(i, 1'b1, w[i]);
                clr_fault = (t == clr_at);
            end
            t++;
        end
        check_eq("vote_latency", 32'(t_seen), 32'(e));
        check_eq("out_valid", 32'(out_valid), 32'(emit));
        check_eq("vote_fail", 32'(vote_fail), 32'(fail));
        check_eq("err_chan", 32'(err_chan), 32'(err));
        model_update(pres, err, clr_at == l + 1);
        check_eq("fault_mask", 32'(fault_mask), 32'(mask_m));
        if (emit) begin
            check_eq("out_data", 32'(out_data), 32'(res));
            check_eq("out_degraded", 32'(out_degraded), 32'(deg));
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if (h == 0) check_eq("err_pulse", 32'({vote_fail, err_chan}), 32'(0));
                check_eq("hold_valid", 32'(out_valid), 32'(1));
                check_eq("hold_data", 32'({out_degraded, out_data}), 32'({deg, res}));
                check_eq("hold_ready", 32'(in_ready), 32'(mask_m));
                drive_background();
                out_ready = (h == hold - 1);
            end
        end
        @(negedge clk);
        check_eq("post_valid", 32'(out_valid), 32'(0));
        check_eq("post_pulse", 32'({vote_fail, err_chan}), 32'(0));
        check_eq("post_ready", 32'(in_ready), 32'(3'b111));
        out_ready = 1'b0;
        drive_background();
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        drive_background();
        clr_fault = 1'b1;
        @(negedge clk);
        clr_fault = 1'b0;
        model_reset();
        drive_background();
        check_eq("clr_mask", 32'(fault_mask), 32'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq(tag, 32'({out_valid, out_data, out_degraded, vote_fail, err_chan, fault_mask}),
                 32'(0));
        check_eq("reset_ready", 32'(in_ready), 32'(3'b111));
    endtask

    initial begin
        logic [2:0]   s;
        logic [W-1:0] base, ww [3];
        logic         got_out;
        rst = 1'b1; in_valid = '0; in_data0 = '0; in_data1 = '0; in_data2 = '0;
        out_ready = 1'b0; clr_fault = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        rst = 1'b0;

        // Clean vote, then a repeated single-bit upset on channel 1.
        run_txn(3'b111, 8'hA5, 8'hA5, 8'hA5, 0, 0, 0, 0, -1);
        repeat (3) run_txn(3'b111, 8'hA5, 8'hA4, 8'hA5, 0, 1, 0, 1, -1);
        check_eq("upset_mask", 32'(fault_mask), 32'(3'b010));
        pulse_clr();

        // Timeout with channel 1 silent.
        run_txn(3'b101, 8'h3C, 8'h00, 8'h3C, 0, 0, 0, 0, -1);

        // Mask channel 0, then two remaining channels conflict.
        repeat (3) run_txn(3'b111, 8'h5A, 8'hA5, 8'hA5, 0, 0, 0, 0, -1);
        check_eq("ch0_mask", 32'(fault_mask), 32'(3'b001));
        run_txn(3'b110, 8'h00, 8'h11, 8'h22, 0, 0, 0, 0, -1);
        pulse_clr();

        // Long backpressure.
        run_txn(3'b111, 8'h96, 8'h96, 8'h96, 2, 0, 1, 10, -1);

        // clr_fault lands in the same cycle as a third fault.
        repeat (2) run_txn(3'b111, 8'hC3, 8'hC3, 8'hC2, 0, 0, 0, 0, -1);
        run_txn(3'b111, 8'hC3, 8'hC3, 8'hC2, 0, 0, 0, 0, 1);
        check_eq("clr_wins", 32'(fault_mask), 32'(0));

        // Randomized transactions.
        for (int n = 0; n < 60; n++) begin
            if (mask_m == 3'b111) begin
                got_out = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    drive_background();
                    got_out = got_out | out_valid | vote_fail;
                    check_eq("all_masked_ready", 32'(in_ready), 32'(3'b111));
                end
                check_eq("all_masked_quiet", 32'(got_out), 32'(0));
                pulse_clr();
            end
            base = W'($urandom);
            for (int i = 0; i < 3; i++) begin
                ww[i] = base;
                if ($urandom_range(9) < 3) ww[i] = base ^ (W'(1) << $urandom_range(W - 1));
                if ($urandom_range(9) == 0) ww[i] = W'($urandom);
            end
            s = ~mask_m;
            if ($urandom_range(3) == 0) s = 3'($urandom) & ~mask_m;
            if (s == 3'b000) s = ~mask_m;
            run_txn(s, ww[0], ww[1], ww[2], $urandom_range(3), $urandom_range(3),
                    $urandom_range(3), $urandom_range(3), -1);
        end

        // Reset while collecting drops the captured word.
        @(negedge clk);
        in_valid = 3'b000;
        set_ch(0, 1'b1, 8'h77);
        repeat (3) begin
            @(negedge clk);
            in_valid = 3'b000;
        end
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset_collect");
        rst = 1'b0;
        model_reset();
        got_out = 1'b0;
        repeat (TMO + 5) begin
            @(negedge clk);
            got_out = got_out | out_valid | vote_fail;
        end
        check_eq("reset_dropped", 32'(got_out), 32'(0));
        run_txn(3'b111, 8'h0F, 8'h0F, 8'h1F, 1, 0, 2, 2, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
